// File: rtl/issue_scheduler_pkg.sv
// Shared types for the reservation station: dispatch entry, issue packet,
// FU ready flags, forwarding bus, plus the wakeup and packet helpers.
package issue_scheduler_pkg;

  localparam int RS_SIZE_DEFAULT = 8;
  localparam int ROB_SIZE_BITS   = 4;
  localparam int PREG_BITS       = 6;
  localparam int XLEN            = 32;

  localparam logic [1:0] FU_ALU1    = 2'd0;
  localparam logic [1:0] FU_ALU2    = 2'd1;
  localparam logic [1:0] FU_MEM     = 2'd2;
  localparam logic [1:0] FU_ILLEGAL = 2'd3;

  typedef struct packed {
    logic                     valid;
    logic [1:0]               fu;
    logic [ROB_SIZE_BITS-1:0] robNum;
    logic [XLEN-1:0]          pc;
    logic [PREG_BITS-1:0]     rd;
    logic [PREG_BITS-1:0]     rd_old;
    logic [PREG_BITS-1:0]     rs1;
    logic                     rs1_rdy;
    logic [XLEN-1:0]          rs1_data;
    logic [PREG_BITS-1:0]     rs2;
    logic                     rs2_rdy;
    logic [XLEN-1:0]          rs2_data;
    logic [XLEN-1:0]          imm;
    logic [3:0]               ALUCtrl;
    logic [7:0]               control;
  } rsEntry;

  typedef struct packed {
    logic                     valid;
    logic [ROB_SIZE_BITS-1:0] robNum;
    logic [XLEN-1:0]          pc;
    logic [PREG_BITS-1:0]     rd;
    logic [PREG_BITS-1:0]     rd_old;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
    logic [XLEN-1:0]          imm;
    logic [3:0]               ALUCtrl;
    logic [7:0]               control;
  } rsIssue;

  typedef struct packed {
    logic alu1;
    logic alu2;
    logic mem;
  } fuRdyStruct;

  typedef struct packed {
    logic                 valid;
    logic [PREG_BITS-1:0] reg_addr;
    logic [XLEN-1:0]      data;
  } forwardingStruct;

  // Bus priority alu1 > alu2 > mem only matters if rename ever reuses a tag.
  function automatic rsEntry wakeup(rsEntry e, forwardingStruct f1,
                                    forwardingStruct f2, forwardingStruct fm);
    rsEntry r = e;
    if (!e.rs1_rdy) begin
      if (f1.valid && f1.reg_addr == e.rs1) begin
        r.rs1_rdy = 1'b1; r.rs1_data = f1.data;
      end else if (f2.valid && f2.reg_addr == e.rs1) begin
        r.rs1_rdy = 1'b1; r.rs1_data = f2.data;
      end else if (fm.valid && fm.reg_addr == e.rs1) begin
        r.rs1_rdy = 1'b1; r.rs1_data = fm.data;
      end
    end
    if (!e.rs2_rdy) begin
      if (f1.valid && f1.reg_addr == e.rs2) begin
        r.rs2_rdy = 1'b1; r.rs2_data = f1.data;
      end else if (f2.valid && f2.reg_addr == e.rs2) begin
        r.rs2_rdy = 1'b1; r.rs2_data = f2.data;
      end else if (fm.valid && fm.reg_addr == e.rs2) begin
        r.rs2_rdy = 1'b1; r.rs2_data = fm.data;
      end
    end
    return r;
  endfunction

  function automatic rsIssue to_issue(rsEntry e);
    rsIssue r;
    r.valid   = 1'b1;
    r.robNum  = e.robNum;
    r.pc      = e.pc;
    r.rd      = e.rd;
    r.rd_old  = e.rd_old;
    r.rs1     = e.rs1_data;
    r.rs2     = e.rs2_data;
    r.imm     = e.imm;
    r.ALUCtrl = e.ALUCtrl;
    r.control = e.control;
    return r;
  endfunction

endpackage

// File: rtl/issue_scheduler_age_select.sv
// Oldest-first picker: one-hot grant of the requesting entry with the
// smallest (robNum - rob_head) modulo the ROB size.
module age_select
  import issue_scheduler_pkg::*;
#(
  parameter int N = RS_SIZE_DEFAULT
) (
  input  logic [N-1:0]                    req,
  input  logic [N-1:0][ROB_SIZE_BITS-1:0] rob_num,
  input  logic [ROB_SIZE_BITS-1:0]        rob_head,
  output logic [N-1:0]                    gnt,
  output logic                            gnt_valid
);

  logic [ROB_SIZE_BITS-1:0] age;
  logic [ROB_SIZE_BITS-1:0] best_age;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    best_age  = '1;
    age       = '0;
    for (int i = 0; i < N; i++) begin
      age = rob_num[i] - rob_head;
      if (req[i] && (!gnt_valid || age < best_age)) begin
        gnt       = '0;
        gnt[i]    = 1'b1;
        gnt_valid = 1'b1;
        best_age  = age;
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Reservation station: two-wide allocation, forwarding wakeup, and
// oldest-ready issue to alu1/alu2 with in-order issue to mem.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  rsEntry                         disp_a,
  input  rsEntry                         disp_b,
  input  logic [ROB_SIZE_BITS-1:0]       rob_head,
  input  fuRdyStruct                     fu_rdy,
  input  forwardingStruct                fwd_alu1,
  input  forwardingStruct                fwd_alu2,
  input  forwardingStruct                fwd_mem,
  output rsIssue                         issue_alu1,
  output rsIssue                         issue_alu2,
  output rsIssue                         issue_mem,
  output logic [$clog2(RS_SIZE+1)-1:0]   free_count,
  output logic                           rs_stall
);

  localparam int CNT_W = $clog2(RS_SIZE + 1);
  localparam int IDX_W = $clog2(RS_SIZE);

  rsEntry rs_q [RS_SIZE];
  rsEntry rs_d [RS_SIZE];
  rsIssue iss_q [3];
  rsEntry sel [3];

  logic [RS_SIZE-1:0]                    ops_rdy;
  logic [RS_SIZE-1:0][ROB_SIZE_BITS-1:0] rob_vec;
  logic [2:0][RS_SIZE-1:0]               req;
  logic [2:0][RS_SIZE-1:0]               gnt;
  logic [2:0]                            gnt_vld;
  logic [2:0]                            fu_rdy_vec;
  logic [2:0]                            fire;
  logic [CNT_W-1:0]                      n_free;
  logic                                  found_a, found_b, wr_a, wr_b;
  logic [IDX_W-1:0]                      idx_a, idx_b, slot_b;

  always_comb begin
    ops_rdy = '0;
    rob_vec = '0;
    req     = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ops_rdy[i]        = rs_q[i].rs1_rdy & rs_q[i].rs2_rdy;
      rob_vec[i]        = rs_q[i].robNum;
      req[FU_ALU1][i]   = rs_q[i].valid && rs_q[i].fu == FU_ALU1 && ops_rdy[i];
      req[FU_ALU2][i]   = rs_q[i].valid && rs_q[i].fu == FU_ALU2 && ops_rdy[i];
      // Mem competes on age alone so a blocked head stalls younger mem ops.
      req[FU_MEM][i]    = rs_q[i].valid && rs_q[i].fu == FU_MEM;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sel
    age_select #(.N(RS_SIZE)) u_age_select (
      .req       (req[g]),
      .rob_num   (rob_vec),
      .rob_head  (rob_head),
      .gnt       (gnt[g]),
      .gnt_valid (gnt_vld[g])
    );
  end

  always_comb begin
    fu_rdy_vec = {fu_rdy.mem, fu_rdy.alu2, fu_rdy.alu1};
    for (int f = 0; f < 3; f++) begin
      sel[f] = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (gnt[f][i]) sel[f] = rs_q[i];
      end
      fire[f] = gnt_vld[f] && fu_rdy_vec[f];
    end
    fire[FU_MEM] = fire[FU_MEM] && sel[FU_MEM].rs1_rdy && sel[FU_MEM].rs2_rdy;
  end

  always_comb begin
    n_free  = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!rs_q[i].valid) begin
        n_free = n_free + CNT_W'(1);
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = IDX_W'(i);
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = IDX_W'(i);
        end
      end
    end
  end

  assign free_count = n_free;
  assign rs_stall   = n_free < CNT_W'(2);
  assign wr_a       = disp_a.valid && disp_a.fu != FU_ILLEGAL && !rs_stall;
  assign wr_b       = disp_b.valid && disp_b.fu != FU_ILLEGAL && !rs_stall;
  assign slot_b     = wr_a ? idx_b : idx_a;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      rs_d[i] = wakeup(rs_q[i], fwd_alu1, fwd_alu2, fwd_mem);
      for (int f = 0; f < 3; f++) begin
        if (fire[f] && gnt[f][i]) rs_d[i].valid = 1'b0;
      end
    end
    if (wr_a) rs_d[idx_a]  = wakeup(disp_a, fwd_alu1, fwd_alu2, fwd_mem);
    if (wr_b) rs_d[slot_b] = wakeup(disp_b, fwd_alu1, fwd_alu2, fwd_mem);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only the valid bits are reset; entry payload is don't-care while invalid.
      for (int i = 0; i < RS_SIZE; i++) rs_q[i].valid <= 1'b0;
      for (int f = 0; f < 3; f++) iss_q[f] <= '0;
    end else begin
      rs_q <= rs_d;
      for (int f = 0; f < 3; f++) begin
        if (fire[f]) iss_q[f] <= to_issue(sel[f]);
        else         iss_q[f].valid <= 1'b0;
      end
    end
  end

  assign issue_alu1 = iss_q[FU_ALU1];
  assign issue_alu2 = iss_q[FU_ALU2];
  assign issue_mem  = iss_q[FU_MEM];

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: reset, latency, age wrap, in-order mem,
// dispatch-time wakeup, illegal fu drop, and fill/stall/drain.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  rsEntry          disp_a, disp_b;
  logic [3:0]      rob_head;
  fuRdyStruct      fu_rdy;
  forwardingStruct fwd_alu1, fwd_alu2, fwd_mem;
  rsIssue          issue_alu1, issue_alu2, issue_mem;
  logic [3:0]      free_count;
  logic            rs_stall;

  int checks   = 0;
  int failures = 0;

  issue_scheduler #(.RS_SIZE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_a     (disp_a),
    .disp_b     (disp_b),
    .rob_head   (rob_head),
    .fu_rdy     (fu_rdy),
    .fwd_alu1   (fwd_alu1),
    .fwd_alu2   (fwd_alu2),
    .fwd_mem    (fwd_mem),
    .issue_alu1 (issue_alu1),
    .issue_alu2 (issue_alu2),
    .issue_mem  (issue_mem),
    .free_count (free_count),
    .rs_stall   (rs_stall)
  );

  always #5 clk = ~clk;

  // Upstream must never dispatch into a stalled station.
  always @(posedge clk) begin
    if (!reset && rs_stall && (disp_a.valid || disp_b.valid)) begin
      failures++;
      $error("FAIL dispatch_during_stall observed=1 expected=0");
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rsEntry mk(logic [1:0] fu, logic [3:0] rob,
                                logic [5:0] s1, logic r1, logic [31:0] d1,
                                logic [5:0] s2, logic r2, logic [31:0] d2);
    rsEntry e = '0;
    e.valid    = 1'b1;
    e.fu       = fu;
    e.robNum   = rob;
    e.pc       = 32'h1000 + 32'(rob) * 4;
    e.rd       = {2'b10, rob};
    e.rd_old   = {2'b01, rob};
    e.rs1      = s1;
    e.rs1_rdy  = r1;
    e.rs1_data = d1;
    e.rs2      = s2;
    e.rs2_rdy  = r2;
    e.rs2_data = d2;
    e.imm      = 32'(rob) + 32'd100;
    e.ALUCtrl  = rob;
    e.control  = {4'hA, rob};
    return e;
  endfunction

  initial begin
    int exp_rob [6] = '{9, 10, 11, 12, 13, 14};
    reset    = 1'b1;
    disp_a   = '0;
    disp_b   = '0;
    rob_head = 4'd0;
    fu_rdy   = '{alu1: 1'b1, alu2: 1'b1, mem: 1'b1};
    fwd_alu1 = '0;
    fwd_alu2 = '0;
    fwd_mem  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_alu1",  issue_alu1, '0);
    check("rst_alu2",  issue_alu2, '0);
    check("rst_mem",   issue_mem, '0);
    check("rst_free",  free_count, 8);
    check("rst_stall", rs_stall, 0);
    tick();
    check("idle_alu1_valid", issue_alu1.valid, 0);
    check("idle_free",       free_count, 8);

    // Ready alu1 op: dispatch in cycle 0, issue visible in cycle 2.
    disp_a = mk(FU_ALU1, 4'd3, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22);
    tick();
    disp_a = '0;
    check("lat_free_c1",   free_count, 7);
    check("lat_valid_c1",  issue_alu1.valid, 0);
    tick();
    check("lat_valid_c2",  issue_alu1.valid, 1);
    check("lat_rob_c2",    issue_alu1.robNum, 3);
    check("lat_rs1_c2",    issue_alu1.rs1, 32'h11);
    check("lat_rs2_c2",    issue_alu1.rs2, 32'h22);
    check("lat_pc_c2",     issue_alu1.pc, 32'h100C);
    check("lat_imm_c2",    issue_alu1.imm, 32'd103);
    tick();
    check("lat_valid_c3",  issue_alu1.valid, 0);
    check("lat_free_c3",   free_count, 8);

    // Age across robNum wrap: head 14, robNum 15 (age 1) beats robNum 1 (age 3).
    rob_head = 4'd14;
    disp_a = mk(FU_ALU2, 4'd1,  6'd3, 1'b1, 32'h101, 6'd4, 1'b1, 32'h102);
    disp_b = mk(FU_ALU2, 4'd15, 6'd5, 1'b1, 32'h151, 6'd6, 1'b1, 32'h152);
    tick();
    disp_a = '0;
    disp_b = '0;
    check("wrap_free", free_count, 6);
    tick();
    check("wrap_first_valid", issue_alu2.valid, 1);
    check("wrap_first_rob",   issue_alu2.robNum, 15);
    check("wrap_alu1_idle",   issue_alu1.valid, 0);
    tick();
    check("wrap_second_valid", issue_alu2.valid, 1);
    check("wrap_second_rob",   issue_alu2.robNum, 1);
    check("wrap_second_rs1",   issue_alu2.rs1, 32'h101);
    tick();
    check("wrap_done_valid", issue_alu2.valid, 0);

    // Mem ordering: robNum 4 waits on p20, robNum 5 is ready but must wait.
    rob_head = 4'd0;
    disp_a = mk(FU_MEM, 4'd4, 6'd20, 1'b0, 32'h0,  6'd7, 1'b1, 32'h44);
    disp_b = mk(FU_MEM, 4'd5, 6'd8,  1'b1, 32'h51, 6'd7, 1'b1, 32'h52);
    tick();
    disp_a = '0;
    disp_b = '0;
    tick();
    check("mem_block_1", issue_mem.valid, 0);
    fwd_alu1 = '{valid: 1'b1, reg_addr: 6'd20, data: 32'hDEAD};
    tick();
    fwd_alu1 = '0;
    check("mem_block_2", issue_mem.valid, 0);
    tick();
    check("mem_head_valid", issue_mem.valid, 1);
    check("mem_head_rob",   issue_mem.robNum, 4);
    check("mem_head_rs1",   issue_mem.rs1, 32'hDEAD);
    check("mem_head_rs2",   issue_mem.rs2, 32'h44);
    tick();
    check("mem_next_valid", issue_mem.valid, 1);
    check("mem_next_rob",   issue_mem.robNum, 5);
    tick();
    check("mem_done_valid", issue_mem.valid, 0);
    check("mem_done_free",  free_count, 8);

    // Wakeup of an incoming dispatch by a same-cycle broadcast.
    disp_a  = mk(FU_ALU1, 4'd6, 6'd10, 1'b1, 32'h1, 6'd9, 1'b0, 32'h0);
    fwd_mem = '{valid: 1'b1, reg_addr: 6'd9, data: 32'h55};
    tick();
    disp_a  = '0;
    fwd_mem = '0;
    tick();
    check("dwake_valid", issue_alu1.valid, 1);
    check("dwake_rob",   issue_alu1.robNum, 6);
    check("dwake_rs2",   issue_alu1.rs2, 32'h55);
    tick();

    // Illegal fu on slot a is dropped; slot b takes the lowest free entry.
    disp_a = mk(FU_ILLEGAL, 4'd7, 6'd1, 1'b1, 32'h7, 6'd2, 1'b1, 32'h7);
    disp_b = mk(FU_ALU2,    4'd2, 6'd1, 1'b1, 32'h21, 6'd2, 1'b1, 32'h22);
    tick();
    disp_a = '0;
    disp_b = '0;
    check("illegal_free", free_count, 7);
    tick();
    check("illegal_alu2_rob",   issue_alu2.robNum, 2);
    check("illegal_alu2_valid", issue_alu2.valid, 1);
    check("illegal_alu1_valid", issue_alu1.valid, 0);
    check("illegal_mem_valid",  issue_mem.valid, 0);
    tick();
    check("illegal_free_after", free_count, 8);

    // Fill to 7 with alu1 held off, then drain oldest-first.
    fu_rdy.alu1 = 1'b0;
    disp_a = mk(FU_ALU1, 4'd10, 6'd1, 1'b1, 32'hA, 6'd2, 1'b1, 32'hA);
    disp_b = mk(FU_ALU1, 4'd8,  6'd1, 1'b1, 32'h8, 6'd2, 1'b1, 32'h8);
    tick();
    disp_a = mk(FU_ALU1, 4'd13, 6'd1, 1'b1, 32'hD, 6'd2, 1'b1, 32'hD);
    disp_b = mk(FU_ALU1, 4'd9,  6'd1, 1'b1, 32'h9, 6'd2, 1'b1, 32'h9);
    tick();
    disp_a = mk(FU_ALU1, 4'd12, 6'd1, 1'b1, 32'hC, 6'd2, 1'b1, 32'hC);
    disp_b = mk(FU_ALU1, 4'd14, 6'd1, 1'b1, 32'hE, 6'd2, 1'b1, 32'hE);
    tick();
    check("fill6_free",  free_count, 2);
    check("fill6_stall", rs_stall, 0);
    disp_a = mk(FU_ALU1, 4'd11, 6'd1, 1'b1, 32'hB, 6'd2, 1'b1, 32'hB);
    disp_b = '0;
    tick();
    disp_a = '0;
    check("fill7_free",  free_count, 1);
    check("fill7_stall", rs_stall, 1);
    tick();
    check("hold_valid", issue_alu1.valid, 0);
    check("hold_free",  free_count, 1);
    fu_rdy.alu1 = 1'b1;
    tick();
    check("drain_rob_0",  issue_alu1.robNum, 8);
    check("drain_valid_0", issue_alu1.valid, 1);
    check("drain_free_0", free_count, 2);
    check("drain_stall_0", rs_stall, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("drain_rob_%0d", k + 1), issue_alu1.robNum, 64'(exp_rob[k]));
      check($sformatf("drain_valid_%0d", k + 1), issue_alu1.valid, 1);
    end
    tick();
    check("drain_done_valid", issue_alu1.valid, 0);
    check("drain_done_free",  free_count, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
